// File: rtl/tx_pattern_gen_if.sv
// Command and output stream bundle for tx_pattern_gen.
// slave is the generator side, master is the RX/TX user side.
interface tx_pattern_gen_if #(
  parameter int OUT_EW = 2
);
  localparam int NB = 1 << OUT_EW;

  logic            i_tready;
  logic            i_tvalid;
  logic [7:0]      i_tdata;
  logic            o_tready;
  logic            o_tvalid;
  logic [8*NB-1:0] o_tdata;
  logic [NB-1:0]   o_tkeep;
  logic            o_tlast;
  logic            o_busy;
  logic            o_done;

  modport slave (
    output i_tready,
    input  i_tvalid, i_tdata,
    input  o_tready,
    output o_tvalid, o_tdata, o_tkeep, o_tlast,
    output o_busy, o_done
  );

  modport master (
    input  i_tready,
    output i_tvalid, i_tdata,
    output o_tready,
    input  o_tvalid, o_tdata, o_tkeep, o_tlast,
    input  o_busy, o_done
  );
endinterface

// File: rtl/tx_pattern_gen.sv
// Length-commanded stream generator: 5-byte command in,
// patterned bytes out with tkeep/tlast framing.
module tx_pattern_gen #(
  parameter int OUT_EW = 2,
  parameter int LEN_W  = 32,
  parameter int PKT_EA = 12
) (
  input logic          clk,
  input logic          rstn,
  tx_pattern_gen_if.slave bus
);
  localparam int NB = 1 << OUT_EW;
  localparam int DW = 8 * NB;
  localparam logic [LEN_W-1:0] NBL = LEN_W'(NB);
  localparam logic [LEN_W-1:0] PMASK =
    LEN_W'((64'd1 << PKT_EA) - 64'd1);

  typedef enum logic {S_CMD, S_GEN} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       cmdm_q, cmdm_d;
  logic [1:0]       mode_q, mode_d;
  logic [23:0]      lbuf_q, lbuf_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [7:0]       prbs_q, prbs_d;
  logic             rdy_q;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             fin_q, fin_d;
  logic             done_q, done_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic [NB-1:0]    keep_q, keep_d;

  function automatic logic [7:0] prbs_nx(
    input logic [7:0] s
  );
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [31:0]      full_len;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_end, start, hs, load;

  assign full_len = {bus.i_tdata, lbuf_q};
  assign cmd_len  = full_len[LEN_W-1:0];
  assign cmd_end  = (state_q == S_CMD) && bus.i_tvalid
                    && rdy_q && (cnt_q == 3'd4);
  assign start    = cmd_end && (cmd_len != '0);
  assign hs       = vld_q & bus.o_tready;
  assign load     = start ||
                    ((state_q == S_GEN) && hs && !fin_q);

  // Beat source: fresh command on start, else running state
  logic [1:0]       s_mode;
  logic [LEN_W-1:0] s_len, s_idx, rem, bidx, b_end;
  logic [7:0]       s_prbs, p_nx;
  logic [DW-1:0]    b_dat;
  logic [NB-1:0]    b_keep;
  logic             b_fin, b_last;

  assign s_mode = start ? cmdm_q : mode_q;
  assign s_len  = start ? cmd_len : len_q;
  assign s_idx  = start ? '0 : idx_q;
  assign s_prbs = start ? 8'hFF : prbs_q;
  assign rem    = s_len - s_idx;
  assign b_end  = s_idx + NBL;
  assign b_fin  = rem <= NBL;
  assign b_last = b_fin || ((b_end & PMASK) == '0);

  always_comb begin
    b_dat  = '0;
    b_keep = '0;
    p_nx   = s_prbs;
    bidx   = '0;
    for (int k = 0; k < NB; k++) begin
      bidx = s_idx + LEN_W'(k);
      if (LEN_W'(k) < rem) begin
        b_keep[k] = 1'b1;
        case (s_mode)
          2'b01: b_dat[8*k +: 8] = 8'h5A;
          2'b10: begin
            b_dat[8*k +: 8] = p_nx;
            p_nx = prbs_nx(p_nx);
          end
          default: b_dat[8*k +: 8] = bidx[7:0];
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmdm_d  = cmdm_q;
    mode_d  = mode_q;
    lbuf_d  = lbuf_q;
    len_d   = len_q;
    idx_d   = idx_q;
    prbs_d  = prbs_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    keep_d  = keep_q;
    last_d  = last_q;
    fin_d   = fin_q;
    done_d  = 1'b0;
    case (state_q)
      S_CMD: begin
        if (bus.i_tvalid && rdy_q) begin
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd0: cmdm_d = bus.i_tdata[1:0];
            3'd1: lbuf_d[7:0]   = bus.i_tdata;
            3'd2: lbuf_d[15:8]  = bus.i_tdata;
            3'd3: lbuf_d[23:16] = bus.i_tdata;
            default: begin
              cnt_d  = 3'd0;
              mode_d = cmdm_q;
              len_d  = cmd_len;
              if (cmd_len == '0) done_d = 1'b1;
              else state_d = S_GEN;
            end
          endcase
        end
      end
      S_GEN: begin
        if (hs && fin_q) begin
          state_d = S_CMD;
          vld_d   = 1'b0;
          dat_d   = '0;
          keep_d  = '0;
          last_d  = 1'b0;
          fin_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_CMD;
    endcase
    if (load) begin
      vld_d  = 1'b1;
      dat_d  = b_dat;
      keep_d = b_keep;
      last_d = b_last;
      fin_d  = b_fin;
      idx_d  = b_end;
      prbs_d = p_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_CMD;
      cnt_q   <= '0;
      cmdm_q  <= '0;
      mode_q  <= '0;
      lbuf_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      prbs_q  <= 8'hFF;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      fin_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmdm_q  <= cmdm_d;
      mode_q  <= mode_d;
      lbuf_q  <= lbuf_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      prbs_q  <= prbs_d;
      rdy_q   <= (state_d == S_CMD);
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      fin_q   <= fin_d;
      done_q  <= done_d;
    end
  end

  assign bus.i_tready = rdy_q;
  assign bus.o_tvalid = vld_q;
  assign bus.o_tdata  = dat_q;
  assign bus.o_tkeep  = keep_q;
  assign bus.o_tlast  = last_q;
  assign bus.o_busy   = (state_q == S_GEN);
  assign bus.o_done   = done_q;
endmodule

// File: tb/tb_tx_pattern_gen.sv
// Randomized bench for tx_pattern_gen against a byte-level
// reference model (OUT_EW=2, PKT_EA=4).
module tb_tx_pattern_gen;
  localparam int OUT_EW = 2;
  localparam int NB     = 4;
  localparam int PKT    = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tx_pattern_gen_if #(.OUT_EW(OUT_EW)) bus ();

  tx_pattern_gen #(
    .OUT_EW(OUT_EW), .LEN_W(32), .PKT_EA(4)
  ) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] exp_d[$], got_d[$];
  logic [3:0]  exp_k[$], got_k[$];
  logic        exp_l[$], got_l[$];

  function automatic void build_expect(
    input logic [7:0] m, input int len
  );
    logic [7:0] bytes[$];
    logic [7:0] s;
    logic [31:0] d;
    logic [3:0] k;
    int n, e;
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    s = 8'hFF;
    for (int i = 0; i < len; i++) begin
      if (m[1:0] == 2'd1) bytes.push_back(8'h5A);
      else if (m[1:0] == 2'd2) begin
        bytes.push_back(s);
        s = ((s << 1) & 8'hFF) | {7'd0, ^(s & 8'hB8)};
      end else bytes.push_back(8'(i % 256));
    end
    for (int b = 0; b * NB < len; b++) begin
      d = 0; k = 0;
      for (int j = 0; j < NB; j++) begin
        n = b * NB + j;
        if (n < len) begin
          d = d | (32'(bytes[n]) << (8 * j));
          k = k | 4'(1 << j);
        end
      end
      e = (b * NB + NB > len) ? len : b * NB + NB;
      exp_d.push_back(d);
      exp_k.push_back(k);
      exp_l.push_back((e % PKT == 0) || (e == len));
    end
  endfunction

  task automatic send_cmd(
    input logic [7:0] m, input logic [31:0] len,
    input bit gaps, output bit to
  );
    logic [7:0] b [5];
    int n;
    b[0] = m; b[1] = len[7:0]; b[2] = len[15:8];
    b[3] = len[23:16]; b[4] = len[31:24];
    to = 0;
    for (int i = 0; i < 5; i++) begin
      if (gaps) repeat ($urandom_range(2, 0)) @(negedge clk);
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = b[i];
      n = 0;
      while (!bus.i_tready && n < 50) begin
        @(negedge clk); n++;
      end
      if (n >= 50) to = 1;
      @(negedge clk);
      bus.i_tvalid = 1'b0;
      bus.i_tdata  = 8'h00;
    end
  endtask

  task automatic run_stream(
    input int nbeats, input int pct,
    output int unstable, output bit to
  );
    bit stalled, r;
    logic [31:0] pd;
    logic [3:0] pk;
    logic pl;
    int cyc;
    got_d.delete(); got_k.delete(); got_l.delete();
    unstable = 0; to = 0; stalled = 0; cyc = 0;
    pd = 0; pk = 0; pl = 0;
    while (got_d.size() < nbeats) begin
      if (cyc > 5000) begin to = 1; break; end
      if (stalled && (bus.o_tvalid !== 1'b1 ||
          bus.o_tdata !== pd || bus.o_tkeep !== pk ||
          bus.o_tlast !== pl)) unstable++;
      r = ($urandom_range(99) < pct);
      bus.o_tready = r;
      stalled = bus.o_tvalid && !r;
      pd = bus.o_tdata; pk = bus.o_tkeep; pl = bus.o_tlast;
      if (bus.o_tvalid && r) begin
        got_d.push_back(bus.o_tdata);
        got_k.push_back(bus.o_tkeep);
        got_l.push_back(bus.o_tlast);
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = 8'h00;
    bus.o_tready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.i_tready, bus.o_tvalid, bus.o_tlast,
         bus.o_busy, bus.o_done} !== 5'b0) begin
      $display("FAIL reset_ctl got=%b want=00000",
        {bus.i_tready, bus.o_tvalid, bus.o_tlast,
         bus.o_busy, bus.o_done});
      bad++;
    end
    total++;
    if (bus.o_tdata !== 32'h0 || bus.o_tkeep !== 4'h0) begin
      $display("FAIL reset_data got=%h/%b want=0/0",
        bus.o_tdata, bus.o_tkeep);
      bad++;
    end
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (bus.i_tready !== 1'b1) begin
      $display("FAIL reset_rdy got=%b want=1", bus.i_tready);
      bad++;
    end
  endtask

  task automatic test_basic();
    bit to;
    int u;
    build_expect(8'h00, 10);
    send_cmd(8'h00, 32'd10, 0, to);
    total++;
    if (to !== 0 || bus.o_tvalid !== 1'b1 ||
        bus.o_busy !== 1'b1 || bus.i_tready !== 1'b0) begin
      $display("FAIL basic_start got=%b%b%b%b want=0110",
        to, bus.o_tvalid, bus.o_busy, bus.i_tready);
      bad++;
    end
    run_stream(3, 100, u, to);
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
          got_l[i] !== exp_l[i]) begin
        $display("FAIL basic_beat%0d got=%h/%b/%b want=%h/%b/%b",
          i, got_d[i], got_k[i], got_l[i],
          exp_d[i], exp_k[i], exp_l[i]);
        bad++;
      end
    end
    total++;
    if (to !== 0 || bus.o_done !== 1'b1 || bus.o_tvalid !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.i_tready !== 1'b1) begin
      $display("FAIL basic_end got=%b%b%b%b%b want=01001",
        to, bus.o_done, bus.o_tvalid, bus.o_busy, bus.i_tready);
      bad++;
    end
    @(negedge clk);
    total++;
    if (bus.o_done !== 1'b0) begin
      $display("FAIL basic_done_pulse got=%b want=0", bus.o_done);
      bad++;
    end
  endtask

  task automatic test_zero_len();
    bit to;
    int u;
    int seen;
    bus.o_tready = 1'b1;
    send_cmd(8'h01, 32'd0, 1, to);
    total++;
    if (to !== 0 || bus.o_done !== 1'b1 || bus.o_tvalid !== 1'b0) begin
      $display("FAIL zero_done got=%b%b%b want=010",
        to, bus.o_done, bus.o_tvalid);
      bad++;
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_tvalid !== 1'b0 || bus.o_done !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      $display("FAIL zero_quiet got=%0d want=0", seen);
      bad++;
    end
    build_expect(8'h00, 5);
    send_cmd(8'h00, 32'd5, 0, to);
    run_stream(2, 100, u, to);
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
          got_l[i] !== exp_l[i]) begin
        $display("FAIL zero_next_beat%0d got=%h/%b/%b want=%h/%b/%b",
          i, got_d[i], got_k[i], got_l[i],
          exp_d[i], exp_k[i], exp_l[i]);
        bad++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_prbs();
    bit to;
    int u;
    build_expect(8'h02, 6);
    send_cmd(8'h02, 32'd6, 1, to);
    run_stream(2, 70, u, to);
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
          got_l[i] !== exp_l[i]) begin
        $display("FAIL prbs_beat%0d got=%h/%b/%b want=%h/%b/%b",
          i, got_d[i], got_k[i], got_l[i],
          exp_d[i], exp_k[i], exp_l[i]);
        bad++;
      end
    end
    total++;
    if (to !== 0 || u !== 0 || bus.o_done !== 1'b1) begin
      $display("FAIL prbs_end got=%b/%0d/%b want=0/0/1",
        to, u, bus.o_done);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_packet();
    bit to;
    int u, nl;
    build_expect(8'h01, 40);
    send_cmd(8'h01, 32'd40, 0, to);
    run_stream(10, 100, u, to);
    nl = 0;
    for (int i = 0; i < exp_d.size(); i++) begin
      if (got_l[i] === 1'b1) nl++;
      total++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
          got_l[i] !== exp_l[i]) begin
        $display("FAIL pkt_beat%0d got=%h/%b/%b want=%h/%b/%b",
          i, got_d[i], got_k[i], got_l[i],
          exp_d[i], exp_k[i], exp_l[i]);
        bad++;
      end
    end
    total++;
    if (nl !== 3 || to !== 0) begin
      $display("FAIL pkt_tlast_count got=%0d want=3", nl);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit to;
    int u, nerr;
    build_expect(8'h00, 1000);
    send_cmd(8'h00, 32'd1000, 1, to);
    run_stream(250, 50, u, to);
    total++;
    if (u !== 0 || to !== 0) begin
      $display("FAIL bp_stable got=%0d/%b want=0/0", u, to);
      bad++;
    end
    nerr = 0;
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
          got_l[i] !== exp_l[i]) begin
        if (nerr < 5)
          $display("FAIL bp_beat%0d got=%h/%b/%b want=%h/%b/%b",
            i, got_d[i], got_k[i], got_l[i],
            exp_d[i], exp_k[i], exp_l[i]);
        nerr++;
        bad++;
      end
    end
    total++;
    if (bus.o_done !== 1'b1 || bus.o_tvalid !== 1'b0) begin
      $display("FAIL bp_end got=%b%b want=10",
        bus.o_done, bus.o_tvalid);
      bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit to;
    int u, len, pct;
    logic [7:0] m;
    for (int it = 0; it < 8; it++) begin
      m   = 8'($urandom);
      len = $urandom_range(200, 1);
      pct = $urandom_range(100, 30);
      build_expect(m, len);
      send_cmd(m, 32'(len), 1, to);
      run_stream(exp_d.size(), pct, u, to);
      for (int i = 0; i < exp_d.size(); i++) begin
        total++;
        if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] ||
            got_l[i] !== exp_l[i]) begin
          $display("FAIL rnd%0d_beat%0d got=%h/%b/%b want=%h/%b/%b",
            it, i, got_d[i], got_k[i], got_l[i],
            exp_d[i], exp_k[i], exp_l[i]);
          bad++;
        end
      end
      total++;
      if (to !== 0 || u !== 0 || bus.o_done !== 1'b1 ||
          bus.o_tvalid !== 1'b0) begin
        $display("FAIL rnd%0d_end got=%b/%0d/%b%b want=0/0/10",
          it, to, u, bus.o_done, bus.o_tvalid);
        bad++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int u;
    bus.o_tready = 1'b0;
    send_cmd(8'h00, 32'd100, 0, to);
    bus.o_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.o_tdata !== 32'h0B0A0908 || bus.o_tvalid !== 1'b1) begin
      $display("FAIL mid_beat3 got=%h/%b want=0b0a0908/1",
        bus.o_tdata, bus.o_tvalid);
      bad++;
    end
    rstn = 1'b0;
    bus.o_tready = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.i_tready, bus.o_tvalid, bus.o_tlast, bus.o_busy,
         bus.o_done} !== 5'b0 || bus.o_tdata !== 32'h0 ||
        bus.o_tkeep !== 4'h0) begin
      $display("FAIL mid_reset got=%b/%h/%b want=00000/0/0",
        {bus.i_tready, bus.o_tvalid, bus.o_tlast, bus.o_busy,
         bus.o_done}, bus.o_tdata, bus.o_tkeep);
      bad++;
    end
    rstn = 1'b1;
    @(negedge clk);
    build_expect(8'h00, 4);
    send_cmd(8'h00, 32'd4, 0, to);
    run_stream(1, 100, u, to);
    total++;
    if (got_d[0] !== 32'h03020100 || got_k[0] !== 4'hF ||
        got_l[0] !== 1'b1 || exp_d[0] !== got_d[0]) begin
      $display("FAIL mid_after got=%h/%b/%b want=03020100/1111/1",
        got_d[0], got_k[0], got_l[0]);
      bad++;
    end
    total++;
    if (to !== 0 || bus.o_done !== 1'b1 || bus.o_tvalid !== 1'b0) begin
      $display("FAIL mid_after_end got=%b%b%b want=010",
        to, bus.o_done, bus.o_tvalid);
      bad++;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_prbs();
    test_packet();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_pattern_gen.md
# tx_pattern_gen

Parametrised length-commanded stream generator for the FTDI 245-fifo example designs. It accepts a 5-byte command on an 8-bit AXI-stream from the RX path and emits the commanded number of bytes on a configurable-width AXI-stream toward the TX path. Output uses selectable data patterns, tkeep on the final partial beat, and tlast at packet boundaries. It sits between `ftdi_245fifo_top` rx and tx ports, clocked by the user clock.

## Interface
- `OUT_EW`, 2: output width exponent; beat = 2^OUT_EW bytes (0..4 → 8..128 bit)
- `LEN_W`, 32: length field width in bits, 8..32; command length bytes above LEN_W are ignored
- `PKT_EA`, 12: packet size = 2^PKT_EA bytes, with PKT_EA ≥ OUT_EW; tlast at every packet end

- `clk`  in  1  sole clock
- `rstn`  in  1  synchronous active-low reset
- `i_tready`  out  1  command byte accept
- `i_tvalid`  in  1  command byte valid
- `i_tdata`  in  8  command byte
- `o_tready`  in  1  downstream ready
- `o_tvalid`  out  1  output beat valid
- `o_tdata`  out  8·2^OUT_EW  output data; stream byte k of a beat is at bits [8k+7:8k]
- `o_tkeep`  out  2^OUT_EW  byte enables
- `o_tlast`  out  1  packet/final beat marker
- `o_busy`  out  1  high in GEN state
- `o_done`  out  1  one-cycle pulse after the final beat handshake, or after a zero-length command

## Operation
- **Command format:** byte0 = mode, bytes 1..4 = length, little-endian (byte1 = LSB).
- **Mode[1:0]:**
  - 00: incrementing; stream byte n = n[7:0].
  - 01: constant 0x5A.
  - 10: PRBS8; the state starts at 0xFF, each byte outputs the current state, then the state becomes {s[6:0], s[7]^s[5]^s[4]^s[3]}.
  - 11: treated as 00.
  - Mode[7:2] is ignored.
- **States:**
  - **CMD:** i_tready=1. Count accepted bytes 0..4. On the 5th byte, latch mode and length, then:
    - if length=0, pulse o_done and stay in CMD;
    - otherwise go to GEN.
  - **GEN:** i_tready=0. Emit ceil(len/2^OUT_EW) beats.
    - Every beat except the last has o_tkeep all ones.
    - The last beat has o_tkeep low (len mod 2^OUT_EW) bits set, or all ones if that remainder is 0. Unused bytes are 0x00.
    - o_tlast=1 when the running byte count reaches a multiple of 2^PKT_EA, or on the last beat.
    - After the last beat handshake, pulse o_done and return to CMD.
- **Pattern continuity:** pattern state (byte index / PRBS) restarts at each command; it is not carried across commands.
- **Width rules:** byte counter width is LEN_W; no wrap within a command. Incrementing pattern wraps mod 256.

## Timing
- **Reset values:** i_tready=0 during reset, 1 on the first cycle after rstn rises. o_tvalid=0, o_tdata=0, o_tkeep=0, o_tlast=0, o_busy=0, o_done=0. Byte count and state reset to CMD/0.
- **Start latency:** 5th command byte accepted at edge N → o_tvalid=1 and first beat valid after edge N+1 (registered outputs). o_busy rises at the same edge.
- **Throughput:** one beat per cycle while o_tready=1.
- **Backpressure:** o_tvalid, o_tdata, o_tkeep and o_tlast hold stable while o_tvalid & !o_tready. o_tvalid never drops without a handshake.
- **End of command:** final handshake at edge M → o_tvalid=0, o_busy=0, o_done=1, i_tready=1 all from M+1. o_done lasts 1 cycle.
- **Zero length:** 5th byte at edge N → o_done=1 for the cycle after N; no output beat.
- **Command gaps:** idle cycles between command bytes (i_tvalid gaps) are allowed. No timeout.
- **Reset mid-operation:** rstn low at any edge aborts GEN/CMD immediately and restores reset values. The partial command is discarded.

## Test plan
- **Basic incrementing (OUT_EW=2):** cmd 00,0A,00,00,00 → beats 0x03020100, 0x07060504, 0x00000908 with tkeep 1111, 1111, 0011; tlast only on beat 3; o_done 1 cycle after.
- **Zero length:** cmd 01,00,00,00,00 → no o_tvalid; o_done single pulse; next command accepted normally.
- **PRBS (OUT_EW=0):** cmd 02,06,00,00,00 → bytes FF, FE, FC, F8, F0, E1; tlast on E1.
- **Packetisation (PKT_EA=4, OUT_EW=2):** cmd 01,28,00,00,00 (40 bytes), constant mode → 10 beats of 0x5A5A5A5A. tlast on beats 4, 8 and 10; tkeep=1111 throughout.
- **Backpressure:** random o_tready (50%) on a 1000-byte incrementing command → outputs stable while stalled; byte sequence 0..255 repeating with no loss or duplication; exactly 250 beats at OUT_EW=2.
- **Reset mid-GEN:** pull rstn low at beat 3 of a 100-byte command → next cycle all outputs at reset values. A subsequent command 00,04,00,00,00 yields 0x03020100 with tlast.
